// File: rtl/kmap_pkg.sv
// -----------------------------------------------------------------------------
// kmap_pkg
// Shared types and constants for the K-map nibble sequencer.
//   nibble_t      : 4-bit input vector of the K-map function
//   state_t       : sequencer FSM state (COLLECT / EVAL)
//   KMAP_DC_MASK  : bit i set => nibble i is a don't-care input of f(x)
//   is_dc()       : true when a nibble lies in the don't-care set
// The don't-care helpers are used by the optional KMAP_DC_CHECK_EN build.
// -----------------------------------------------------------------------------
package kmap_pkg;

  typedef logic [3:0] nibble_t;

  typedef enum logic {
    COLLECT = 1'b0,
    EVAL    = 1'b1
  } state_t;

  // Don't-care nibbles: 0x0, 0x1, 0x3, 0x5, 0xA, 0xD, 0xF.
  localparam logic [15:0] KMAP_DC_MASK = 16'hA42B;

  function automatic logic is_dc(input nibble_t n);
    return KMAP_DC_MASK[n];
  endfunction

endpackage : kmap_pkg

// File: rtl/kmap_nibble_sequencer_if.sv
// -----------------------------------------------------------------------------
// kmap_nibble_sequencer_if
// Valid/ready result port of the K-map nibble sequencer.
//   out_valid : result register holds an undelivered result
//   out_ready : consumer accepts the result this cycle
//   out_x     : nibble of the held result
//   out_f     : function value of the held result
//   out_dc    : held nibble is a don't-care (only with KMAP_DC_CHECK_EN)
// Modports: master = producer (sequencer), slave = consumer.
// -----------------------------------------------------------------------------
interface kmap_nibble_sequencer_if;
  import kmap_pkg::*;

  logic    out_valid;
  logic    out_ready;
  nibble_t out_x;
  logic    out_f;
`ifdef KMAP_DC_CHECK_EN
  logic    out_dc;
`endif

  modport master (
    output out_valid,
    output out_x,
    output out_f,
`ifdef KMAP_DC_CHECK_EN
    output out_dc,
`endif
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_x,
    input  out_f,
`ifdef KMAP_DC_CHECK_EN
    input  out_dc,
`endif
    output out_ready
  );

endinterface : kmap_nibble_sequencer_if

// File: rtl/kmap_serial_to_nibble.sv
// -----------------------------------------------------------------------------
// kmap_serial_to_nibble
// Shift register and 2-bit bit counter that assemble a serial stream into
// 4-bit nibbles. Never stalls: every in_valid cycle consumes in_bit.
//   clk, aresetn   : clock, asynchronous active-low reset
//   in_bit         : serial data bit
//   in_valid       : in_bit accepted this cycle
//   nibble         : nibble including the bit accepted this cycle
//   nibble_done    : this cycle's bit completes a nibble (bit_cnt == 3)
// Parameter MSB_FIRST: 1 => first bit lands in nibble[3], 0 => in nibble[0].
// nibble/nibble_done are combinational so the parent can register the
// completed nibble at the same edge that accepts the 4th bit.
// -----------------------------------------------------------------------------
module kmap_serial_to_nibble
  import kmap_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic    clk,
  input  logic    aresetn,
  input  logic    in_bit,
  input  logic    in_valid,
  output nibble_t nibble,
  output logic    nibble_done
);

  nibble_t    shift_q;
  nibble_t    shift_d;
  logic [1:0] bit_cnt;

  // NOTE: always_comb blocks assign every output unconditionally so no latch
  // is inferred.
  always_comb begin
    shift_d = MSB_FIRST ? {shift_q[2:0], in_bit} : {in_bit, shift_q[3:1]};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else if (in_valid) begin
      shift_q <= shift_d;
      bit_cnt <= bit_cnt + 2'd1;  // wraps 3 -> 0 on the 4th bit
    end
  end

  assign nibble      = shift_d;
  assign nibble_done = in_valid && (bit_cnt == 2'd3);

endmodule : kmap_serial_to_nibble

// File: rtl/kmap_nibble_sequencer.sv
// -----------------------------------------------------------------------------
// kmap_nibble_sequencer
// Wraps the combinational K-map function f(x): assembles serial bits into a
// registered nibble x, samples f one cycle later (EVAL), and presents {x, f}
// on a registered valid/ready port. Counts delivered results and flags
// dropped ones.
//   clk, aresetn : clock, asynchronous active-low reset
//   in_bit       : serial data bit
//   in_valid     : in_bit accepted this cycle (no backpressure)
//   x            : registered nibble driven to the function block
//   f            : combinational function result for the current x
//   overrun      : sticky, a result was dropped because the slot was full
//   result_cnt   : completed output handshakes, wraps at 2^COUNT_W
//   res          : result port (out_valid/out_ready/out_x/out_f[/out_dc])
// Parameters: MSB_FIRST (bit order), COUNT_W (result counter width).
// Optional build macro KMAP_DC_CHECK_EN adds out_dc and forces out_f to 0 for
// don't-care nibbles so no X leaves the block.
// -----------------------------------------------------------------------------
module kmap_nibble_sequencer
  import kmap_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1,
  parameter int COUNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 in_bit,
  input  logic                 in_valid,
  output nibble_t              x,
  input  logic                 f,
  output logic                 overrun,
  output logic [COUNT_W-1:0]   result_cnt,
  kmap_nibble_sequencer_if.master res
);

  nibble_t nibble;
  logic    nibble_done;

  state_t  state_q;
  state_t  state_d;
  logic    load;
  logic    drop;
  logic    handshake;
  logic    f_eff;

  kmap_serial_to_nibble #(
    .MSB_FIRST (MSB_FIRST)
  ) u_s2n (
    .clk         (clk),
    .aresetn     (aresetn),
    .in_bit      (in_bit),
    .in_valid    (in_valid),
    .nibble      (nibble),
    .nibble_done (nibble_done)
  );

  // EVAL lasts exactly one cycle after each completed nibble; a new nibble
  // finishing during EVAL simply schedules the next EVAL.
  always_comb begin
    state_d   = nibble_done ? EVAL : COLLECT;
    handshake = res.out_valid && res.out_ready;
    load      = 1'b0;
    drop      = 1'b0;
    if (state_q == EVAL) begin
      // Slot is usable if empty or being emptied by this cycle's handshake.
      if (!res.out_valid || res.out_ready) load = 1'b1;
      else                                 drop = 1'b1;
    end
  end

`ifdef KMAP_DC_CHECK_EN
  assign f_eff = is_dc(x) ? 1'b0 : f;
`else
  assign f_eff = f;
`endif

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= COLLECT;
      x       <= '0;
    end else begin
      state_q <= state_d;
      // f for the previous x has already been sampled by load at this edge.
      if (nibble_done) x <= nibble;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      res.out_valid <= 1'b0;
      res.out_x     <= '0;
      res.out_f     <= 1'b0;
`ifdef KMAP_DC_CHECK_EN
      res.out_dc    <= 1'b0;
`endif
    end else if (load) begin
      res.out_valid <= 1'b1;
      res.out_x     <= x;
      res.out_f     <= f_eff;
`ifdef KMAP_DC_CHECK_EN
      res.out_dc    <= is_dc(x);
`endif
    end else if (handshake) begin
      res.out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      overrun    <= 1'b0;
      result_cnt <= '0;
    end else begin
      if (drop)      overrun    <= 1'b1;
      if (handshake) result_cnt <= result_cnt + 1'b1;
    end
  end

endmodule : kmap_nibble_sequencer

// File: tb/tb_kmap_nibble_sequencer.sv
// -----------------------------------------------------------------------------
// tb_kmap_nibble_sequencer
// Directed bench for kmap_nibble_sequencer. Two instances share the serial
// input: u_msb (MSB_FIRST=1) and u_lsb (MSB_FIRST=0), each with its own copy
// of the K-map function model on its x. With KMAP_DC_CHECK_EN defined the
// don't-care path is exercised too.
// -----------------------------------------------------------------------------
module tb_kmap_nibble_sequencer;

  logic       clk = 1'b0;
  logic       aresetn;
  logic       in_bit;
  logic       in_valid;
  logic       out_ready;

  logic [3:0] x_m, x_l;
  logic       f_m, f_l;
  logic       ovr_m, ovr_l;
  logic [7:0] cnt_m, cnt_l;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // K-map function model: 1 on {4,6,B,C,E}, 0 on {2,7,8,9}, X on don't-cares.
  function automatic logic kmap_f(input logic [3:0] n);
    case (n)
      4'h4, 4'h6, 4'hB, 4'hC, 4'hE: return 1'b1;
      4'h2, 4'h7, 4'h8, 4'h9:       return 1'b0;
      default:                      return 1'bx;
    endcase
  endfunction

  assign f_m = kmap_f(x_m);
  assign f_l = kmap_f(x_l);

  kmap_nibble_sequencer_if res_m ();
  kmap_nibble_sequencer_if res_l ();
  assign res_m.out_ready = out_ready;
  assign res_l.out_ready = out_ready;

  kmap_nibble_sequencer #(.MSB_FIRST(1'b1), .COUNT_W(8)) u_msb (
    .clk        (clk),
    .aresetn    (aresetn),
    .in_bit     (in_bit),
    .in_valid   (in_valid),
    .x          (x_m),
    .f          (f_m),
    .overrun    (ovr_m),
    .result_cnt (cnt_m),
    .res        (res_m)
  );

  kmap_nibble_sequencer #(.MSB_FIRST(1'b0), .COUNT_W(8)) u_lsb (
    .clk        (clk),
    .aresetn    (aresetn),
    .in_bit     (in_bit),
    .in_valid   (in_valid),
    .x          (x_l),
    .f          (f_l),
    .overrun    (ovr_l),
    .result_cnt (cnt_l),
    .res        (res_l)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_bit   = 1'b0;
    tick();
  endtask

  // Mid-cycle asynchronous reset pulse.
  task automatic pulse_reset();
    in_valid = 1'b0;
    #2 aresetn = 1'b0;
    #2 aresetn = 1'b1;
  endtask

  initial begin
    aresetn   = 1'b0;
    in_bit    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_x",       32'(x_m), 32'h0);
    check("rst_valid",   32'(res_m.out_valid), 32'h0);
    check("rst_out_x",   32'(res_m.out_x), 32'h0);
    check("rst_out_f",   32'(res_m.out_f), 32'h0);
    check("rst_overrun", 32'(ovr_m), 32'h0);
    check("rst_cnt",     32'(cnt_m), 32'h0);
    aresetn = 1'b1;

    // Single nibble 0,1,0,0 -> x=4, then result (4,1), then one transfer.
    out_ready = 1'b1;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    check("t1_x", 32'(x_m), 32'h4);
    check("t1_valid_early", 32'(res_m.out_valid), 32'h0);
    idle();
    check("t1_valid", 32'(res_m.out_valid), 32'h1);
    check("t1_out_x", 32'(res_m.out_x), 32'h4);
    check("t1_out_f", 32'(res_m.out_f), 32'h1);
    idle();
    check("t1_cnt",   32'(cnt_m), 32'h1);
    check("t1_valid_drop", 32'(res_m.out_valid), 32'h0);

    // Back-to-back nibbles 7 then 8.
    pulse_reset();
    tick();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    check("t2_x7", 32'(x_m), 32'h7);
    send_bit(1'b1);
    check("t2_valid7", 32'(res_m.out_valid), 32'h1);
    check("t2_out_x7", 32'(res_m.out_x), 32'h7);
    check("t2_out_f7", 32'(res_m.out_f), 32'h0);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    check("t2_x8", 32'(x_m), 32'h8);
    check("t2_cnt_mid", 32'(cnt_m), 32'h1);
    idle();
    check("t2_out_x8", 32'(res_m.out_x), 32'h8);
    check("t2_out_f8", 32'(res_m.out_f), 32'h0);
    idle();
    check("t2_cnt", 32'(cnt_m), 32'h2);
    check("t2_overrun", 32'(ovr_m), 32'h0);

    // Reset mid-nibble: two bits then async reset; partial bits discarded.
    send_bit(1'b1); send_bit(1'b0);
    #3 aresetn = 1'b0;
    in_valid = 1'b0;
    #1;
    check("t4_x",     32'(x_m), 32'h0);
    check("t4_valid", 32'(res_m.out_valid), 32'h0);
    check("t4_out_x", 32'(res_m.out_x), 32'h0);
    check("t4_cnt",   32'(cnt_m), 32'h0);
    tick();
    aresetn = 1'b1;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    check("t4_xb", 32'(x_m), 32'hB);
    idle();
    check("t4_out_x", 32'(res_m.out_x), 32'hB);
    check("t4_out_f", 32'(res_m.out_f), 32'h1);

    // Held output: 0x6 loaded, 0xC dropped, overrun sticky.
    pulse_reset();
    out_ready = 1'b0;
    tick();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    idle();
    check("t3_valid", 32'(res_m.out_valid), 32'h1);
    check("t3_out_x6", 32'(res_m.out_x), 32'h6);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    check("t3_xc", 32'(x_m), 32'hC);
    check("t3_no_ovr_yet", 32'(ovr_m), 32'h0);
    idle();
    check("t3_overrun", 32'(ovr_m), 32'h1);
    check("t3_hold_x", 32'(res_m.out_x), 32'h6);
    check("t3_hold_f", 32'(res_m.out_f), 32'h1);
    check("t3_cnt0", 32'(cnt_m), 32'h0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t3_cnt1", 32'(cnt_m), 32'h1);
    check("t3_valid_off", 32'(res_m.out_valid), 32'h0);
    tick();
    check("t3_sticky", 32'(ovr_m), 32'h1);

    // LSB-first ordering on u_lsb.
    pulse_reset();
    out_ready = 1'b1;
    tick();
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    check("t5_x_b", 32'(x_l), 32'hB);
    idle();
    check("t5_out_x_b", 32'(res_l.out_x), 32'hB);
    check("t5_out_f_b", 32'(res_l.out_f), 32'h1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    check("t5_x_e", 32'(x_l), 32'hE);
    idle();
    check("t5_out_x_e", 32'(res_l.out_x), 32'hE);
    check("t5_out_f_e", 32'(res_l.out_f), 32'h1);
    idle();
    check("t5_cnt", 32'(cnt_l), 32'h2);

`ifdef KMAP_DC_CHECK_EN
    // Don't-care nibble 0xA forces out_f to 0 and raises out_dc.
    pulse_reset();
    tick();
    check("dc_rst", 32'(res_m.out_dc), 32'h0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    idle();
    check("dc_a_x",  32'(res_m.out_x), 32'hA);
    check("dc_a_dc", 32'(res_m.out_dc), 32'h1);
    check("dc_a_f",  32'(res_m.out_f), 32'h0);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    idle();
    check("dc_2_x",  32'(res_m.out_x), 32'h2);
    check("dc_2_dc", 32'(res_m.out_dc), 32'h0);
    check("dc_2_f",  32'(res_m.out_f), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_kmap_nibble_sequencer
